// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: FSM state encoding, data
// width, default bit-period divisor and the even-parity helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_DIVISOR = 1042;  // 10 MHz / 9600 baud

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Even parity: XOR of all data bits, so data plus parity has an even count of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Loadable bit-period down-counter. Counts DIVISOR-1 .. 0 while enabled and
// raises tick for one clock at count 0, reloading itself on that clock.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous reset, active-high (count cleared)
//   load   in  load DIVISOR-1 (takes priority over counting)
//   enable in  count while high; tick is suppressed while low
//   tick   out one-clock pulse at each bit boundary
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] count;

  // Bit-period down-counter with load priority and wrap-to-reload at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= RELOAD;
    end else if (enable) begin
      if (count == {CNT_W{1'b0}}) begin
        count <= RELOAD;
      end else begin
        count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      count <= count;
    end
  end

  assign tick = enable && (count == {CNT_W{1'b0}});

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Byte-wide UART transmitter, 8N1 by default. Defining UART_TX_PARITY_EN adds
// an even-parity bit between the data bits and the stop bit (8E1).
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   tx_data   in   [7:0] byte to send, sampled only on acceptance
//   tx_valid  in   producer has a byte on tx_data
//   tx_ready  out  can accept (IDLE and not in reset); transfer = valid && ready
//   tx_out    out  registered serial line, idle high
//   busy      out  registered, high while a frame is in flight
// Parameters: DIVISOR clocks per bit (2..65535), CNT_W counter width
// (2**CNT_W > DIVISOR).
// -----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy
);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 accept;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign tx_ready = (state == ST_IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  // The counter is loaded on acceptance so the START bit gets a full period.
  uart_baud_tick #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .enable (busy),
    .tick   (tick)
  );

  // Frame FSM; tx_out is registered with the value for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
      shift   <= {DATA_BITS{1'b0}};
      bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift   <= tx_data;
            bit_idx <= 3'd0;
            state   <= ST_START;
            tx_out  <= 1'b0;
            busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(tx_data);
`endif
          end
        end
        ST_START: begin
          if (tick) begin
            state  <= ST_DATA;
            tx_out <= shift[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              tx_out  <= parity_bit;
`else
              state   <= ST_STOP;
              tx_out  <= 1'b1;
`endif
            end else begin
              // LSB first: the next bit to drive is shift[1] before the shift lands.
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx_out  <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state  <= ST_STOP;
            tx_out <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            state  <= ST_IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        end
        default: begin
          // Unreachable encodings recover to a quiet idle line.
          state  <= ST_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       ferr;
  } rx_t;

  rx_t        rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_serializer #(.DIVISOR(DIV), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent UART receiver: samples mid-bit on falling clock edges.
  logic [7:0] dec_byte = 8'h00;
  logic       dec_par = 1'b0;
  logic       dec_ferr = 1'b0;
  logic       dec_active = 1'b0;
  int         dec_pos = 0;

  always @(negedge clk) begin
    if (rst) begin
      dec_active <= 1'b0;
      dec_pos    <= 0;
    end else if (!dec_active) begin
      if (tx_out === 1'b0) begin
        dec_active <= 1'b1;
        dec_pos    <= 1;
        dec_ferr   <= 1'b0;
      end
    end else begin
      dec_pos <= dec_pos + 1;
      if (dec_pos % DIV == DIV / 2) begin
        if (dec_pos / DIV == 0) begin
          if (tx_out !== 1'b0) dec_ferr <= 1'b1;
        end else if (dec_pos / DIV <= 8) begin
          dec_byte[3'(dec_pos / DIV - 1)] <= tx_out;
        end else if (dec_pos / DIV < NB - 1) begin
          dec_par <= tx_out;
        end else begin
          rx_q.push_back({dec_byte, dec_par, dec_ferr | (tx_out !== 1'b1)});
          dec_active <= 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a byte and return #1 after the accepting edge.
  task automatic accept_byte(input logic [7:0] d, input bit hold, output bit ok);
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 0; n < 4 * FRAME && !ok; n++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      exp_q.push_back(d);
      if (!hold) tx_valid = 1'b0;
    end else begin
      checks++; errors++;
      $display("FAIL accept_timeout: byte %h not accepted, tx_ready=%b", d, tx_ready);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_rx(input int n, input int bound);
    for (int c = 0; c < bound && rx_q.size() < n; c++) step();
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL rx_timeout: got %0d frames want %0d", rx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", tx_ready); end
    end
    rst = 1'b0; tx_valid = 1'b0;
    #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", tx_ready); end
    step();
    checks++; if (busy !== 1'b0 || tx_out !== 1'b1) begin errors++; $display("FAIL reset_no_accept: busy=%b tx_out=%b want 0/1", busy, tx_out); end
  endtask

  task automatic test_single_byte();
    logic [7:0]    d;
    logic [NB-1:0] fr;
    bit            ok;
    rx_t           r;
    d = 8'hA5;
    rx_q.delete(); exp_q.delete();
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
`ifdef UART_TX_PARITY_EN
    fr[9] = ^d;
`endif
    checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b want 1", tx_out); end
    accept_byte(d, 1'b0, ok);
    if (ok) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      for (int i = 0; i <= FRAME; i++) begin
        if (i < FRAME) begin
          checks++;
          if (tx_out !== fr[i / DIV]) begin errors++; $display("FAIL single_line clk %0d: got %b want %b", i, tx_out, fr[i / DIV]); end
        end
        if (i >= FRAME - 1) begin
          checks++;
          if (tx_ready !== (i == FRAME)) begin errors++; $display("FAIL single_ready clk %0d: got %b want %b", i, tx_ready, (i == FRAME)); end
        end
        if (i < FRAME) step();
      end
      wait_rx(1, 2 * FRAME);
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        checks++; if (r.data !== d || r.ferr !== 1'b0) begin errors++; $display("FAIL single_decode: got %h ferr=%b want %h", r.data, r.ferr, d); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit  ok;
    int  ready_cnt;
    rx_t r;
    rx_q.delete(); exp_q.delete();
    ready_cnt = 0;
    accept_byte(8'h00, 1'b1, ok);
    if (ok) begin
      tx_data = 8'hFF;
      for (int i = 1; i <= FRAME + 1; i++) begin
        step();
        if (tx_ready === 1'b1) ready_cnt++;
        if (i == FRAME) begin
          checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL b2b_stop_ext: got %b want 1", tx_out); end
        end
        if (i == FRAME + 1) begin
          checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL b2b_second_start: got %b want 0 at clk %0d", tx_out, i); end
        end
      end
      tx_valid = 1'b0;
      exp_q.push_back(8'hFF);
      checks++; if (ready_cnt != 1) begin errors++; $display("FAIL b2b_ready_gap: got %0d ready clks want 1", ready_cnt); end
      wait_rx(2, 3 * FRAME);
      for (int k = 0; k < 2 && rx_q.size() > 0 && exp_q.size() > 0; k++) begin
        r = rx_q.pop_front();
        checks++;
        if (r.data !== exp_q[0] || r.ferr !== 1'b0) begin errors++; $display("FAIL b2b_decode %0d: got %h ferr=%b want %h", k, r.data, r.ferr, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_mid_frame();
    bit  ok;
    int  low_cnt;
    rx_t r;
    rx_q.delete(); exp_q.delete();
    accept_byte(8'h3C, 1'b0, ok);
    if (ok) begin
      repeat (10) step();
      tx_data = 8'hC3; tx_valid = 1'b1;
      step(); step();
      tx_valid = 1'b0; tx_data = 8'h00;
      wait_rx(1, 2 * FRAME);
      low_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        if (tx_out !== 1'b1) low_cnt++;
      end
      checks++; if (low_cnt != 0) begin errors++; $display("FAIL mid_extra_frame: got %0d low clks want 0", low_cnt); end
      checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL mid_frame_count: got %0d frames want 1", rx_q.size()); end
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        checks++; if (r.data !== 8'h3C || r.ferr !== 1'b0) begin errors++; $display("FAIL mid_decode: got %h ferr=%b want 3c", r.data, r.ferr); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int low_cnt;
    rx_q.delete(); exp_q.delete();
    accept_byte(8'hF0, 1'b0, ok);
    if (ok) begin
      repeat (4 * 4 + 1) step();
      checks++; if (tx_out !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b want 0", tx_out); end
      rst = 1'b1;
      step();
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL rstmid_line: got %b want 1", tx_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b want 0", tx_ready); end
      rst = 1'b0;
      #1;
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b want 1", tx_ready); end
      low_cnt = 0;
      for (int i = 0; i < FRAME + 8; i++) begin
        step();
        if (tx_out !== 1'b1) low_cnt++;
      end
      checks++; if (low_cnt != 0 || rx_q.size() != 0) begin errors++; $display("FAIL rstmid_no_completion: got %0d low clks %0d frames want 0 0", low_cnt, rx_q.size()); end
      exp_q.delete();
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] pd [2];
    logic       pe [2];
    bit         ok;
    rx_t        r;
    pd[0] = 8'h07; pe[0] = 1'b1;
    pd[1] = 8'h03; pe[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rx_q.delete(); exp_q.delete();
      accept_byte(pd[k], 1'b0, ok);
      if (ok) begin
        for (int i = 1; i <= FRAME; i++) begin
          step();
          if (i == 9 * DIV + 1) begin
            checks++; if (tx_out !== pe[k]) begin errors++; $display("FAIL parity_bit %h: got %b want %b", pd[k], tx_out, pe[k]); end
          end
          if (i >= FRAME - 1) begin
            checks++; if (tx_ready !== (i == FRAME)) begin errors++; $display("FAIL parity_len clk %0d: got %b want %b", i, tx_ready, (i == FRAME)); end
          end
        end
        wait_rx(1, 2 * FRAME);
        if (rx_q.size() > 0) begin
          r = rx_q.pop_front();
          checks++; if (r.data !== pd[k] || r.par !== pe[k] || r.ferr !== 1'b0) begin errors++; $display("FAIL parity_decode: got %h par=%b ferr=%b want %h par=%b", r.data, r.par, r.ferr, pd[k], pe[k]); end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    bit         ok;
    int         gap;
    logic [7:0] d;
    logic [7:0] e;
    rx_t        r;
    rx_q.delete(); exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      gap = $urandom_range(0, 3);
      tx_valid = 1'b0;
      repeat (gap) step();
      d = 8'($urandom_range(0, 255));
      accept_byte(d, 1'b0, ok);
    end
    wait_rx(exp_q.size(), 4 * FRAME);
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d frames want %0d", rx_q.size(), exp_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (r.data !== e) begin errors++; $display("FAIL rand_data: got %h want %h", r.data, e); end
      checks++; if (r.ferr !== 1'b0) begin errors++; $display("FAIL rand_framing: got ferr=%b want 0 for %h", r.ferr, e); end
`ifdef UART_TX_PARITY_EN
      checks++; if (r.par !== ^e) begin errors++; $display("FAIL rand_parity: got %b want %b for %h", r.par, ^e, e); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_mid_frame();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
